// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer between the fetch and load/store ports and a single-port,
// word-wide, one-cycle-latency data memory. Partial stores run as read-modify-write.
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_data,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic              ls_req_we,
    input  logic [3:0]        ls_req_be,
    input  logic [31:0]       ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_resp_valid,
    output logic [31:0]       ls_resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RMW,
        ACK
    } state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_LS
    } grant_t;

    state_t            state;
    state_t            state_next;
    grant_t            last_grant;
    grant_t            winner;
    logic              accept;
    logic              store_accept;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_word;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       merged;

    // Byte-offset bits never reach the word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_req_addr[1:0], ls_req_addr[1:0]};

    // Lone requester wins; under contention the port not served last time wins.
    always_comb begin
        winner = GRANT_IF;
        if (if_req_valid && ls_req_valid) begin
            winner = (last_grant == GRANT_IF) ? GRANT_LS : GRANT_IF;
        end else if (ls_req_valid) begin
            winner = GRANT_LS;
        end
    end

    assign if_req_ready = (state == IDLE) && if_req_valid && (winner == GRANT_IF);
    assign ls_req_ready = (state == IDLE) && ls_req_valid && (winner == GRANT_LS);
    assign accept       = if_req_ready || ls_req_ready;
    assign store_accept = ls_req_ready && ls_req_we;
    assign req_addr     = (winner == GRANT_LS) ? ls_req_addr : if_req_addr;
    assign req_word     = {2'b00, req_addr[ADDR_W-1:2]};

    // Enabled lanes come from the store data, the rest from the word read at accept.
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next    = state;
        mem_addr      = addr_q;
        mem_we        = 1'b0;
        mem_wdata     = mem_wdata_q;
        if_resp_valid = 1'b0;
        if_resp_data  = 32'h0;
        ls_resp_valid = 1'b0;
        ls_resp_data  = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    mem_addr = req_word;
                    if (store_accept) begin
                        if (ls_req_be == 4'hF) begin
                            mem_we     = 1'b1;
                            mem_wdata  = ls_req_wdata;
                            state_next = ACK;
                        end else if (ls_req_be == 4'h0) begin
                            state_next = ACK;
                        end else begin
                            state_next = RMW;
                        end
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (last_grant == GRANT_IF) begin
                    if_resp_valid = 1'b1;
                    if_resp_data  = mem_rdata;
                end else begin
                    ls_resp_valid = 1'b1;
                    ls_resp_data  = mem_rdata;
                end
                state_next = IDLE;
            end
            RMW: begin
                mem_we     = 1'b1;
                mem_wdata  = merged;
                state_next = ACK;
            end
            ACK: begin
                ls_resp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_IF;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= winner;
                addr_q     <= req_word;
                wdata_q    <= ls_req_wdata;
                be_q       <= ls_req_be;
            end
            if (mem_we) begin
                mem_wdata_q <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_memory and a response scoreboard.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [31:0]       if_resp_data;
    logic              ls_req_valid;
    logic [ADDR_W-1:0] ls_req_addr;
    logic              ls_req_we;
    logic [3:0]        ls_req_be;
    logic [31:0]       ls_req_wdata;
    logic              ls_req_ready;
    logic              ls_resp_valid;
    logic [31:0]       ls_resp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_resp_valid(if_resp_valid),
        .if_resp_data (if_resp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_addr  (ls_req_addr),
        .ls_req_we    (ls_req_we),
        .ls_req_be    (ls_req_be),
        .ls_req_wdata (ls_req_wdata),
        .ls_req_ready (ls_req_ready),
        .ls_resp_valid(ls_resp_valid),
        .ls_resp_data (ls_resp_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        logic [31:0] data;
        int          due;
        bit          is_store;
        int          idx;
        logic [31:0] wval;
    } exp_t;

    exp_t        sb[$];
    bit          grant_log[$];
    logic [31:0] mem[64];
    logic [31:0] ref_mem[64];
    int          cycle = 0;
    int          writes_seen = 0;
    int          checks = 0;
    int          passed = 0;
    int          failed = 0;
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    // Behavioural data_memory: registered read returning the pre-write word.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            writes_seen <= writes_seen + 1;
        end
        mem_rdata <= mem[mem_addr[5:0]];
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) begin
            r[8*l +: 8] = be[l] ? new_w[8*l +: 8] : old_w[8*l +: 8];
        end
        return r;
    endfunction

    task automatic take_resp(input bit is_ls, input logic [31:0] data);
        exp_t e;
        check("resp_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_port", 32'(is_ls), 32'(e.is_ls));
            check("resp_data", data, e.data);
            check("resp_cycle", 32'(cycle), 32'(e.due));
            if (e.is_store) ref_mem[e.idx] = e.wval;
        end
    endtask

    // Scoreboard: expectations queued at accept, retired when a response pulse appears.
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (pre_we) ref_mem[pre_idx] = pre_data;
            if (if_resp_valid || ls_resp_valid)
                check("one_resp_per_cycle", 32'(if_resp_valid && ls_resp_valid), 32'd0);
            if (if_resp_valid) take_resp(1'b0, if_resp_data);
            if (ls_resp_valid) take_resp(1'b1, ls_resp_data);
            if (sb.size() > 0 && cycle > sb[0].due) begin
                check("resp_timeout", 32'(cycle), 32'(sb[0].due));
                void'(sb.pop_front());
            end
            if (if_req_valid && if_req_ready) begin
                grant_log.push_back(1'b0);
                idx = int'(if_req_addr[7:2]);
                e = '{is_ls: 1'b0, data: ref_mem[idx], due: cycle + 1,
                      is_store: 1'b0, idx: idx, wval: 32'h0};
                sb.push_back(e);
            end
            if (ls_req_valid && ls_req_ready) begin
                grant_log.push_back(1'b1);
                idx = int'(ls_req_addr[7:2]);
                if (ls_req_we) begin
                    e = '{is_ls: 1'b1, data: 32'h0,
                          due: cycle + ((ls_req_be != 4'h0 && ls_req_be != 4'hF) ? 2 : 1),
                          is_store: 1'b1, idx: idx,
                          wval: merge(ref_mem[idx], ls_req_wdata, ls_req_be)};
                end else begin
                    e = '{is_ls: 1'b1, data: ref_mem[idx], due: cycle + 1,
                          is_store: 1'b0, idx: idx, wval: 32'h0};
                end
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_idx  = idx[5:0];
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic wait_ready(input bit is_ls, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (is_ls ? ls_req_ready : if_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        bit ok;
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        wait_ready(1'b0, ok);
        check("fetch_ready", 32'(ok), 32'd1);
        if (ok) begin
            check("fetch_mem_addr", mem_addr, addr >> 2);
            check("fetch_mem_we", 32'(mem_we), 32'd0);
        end
        tick();
        if_req_valid = 1'b0;
    endtask

    task automatic do_ls(input logic [31:0] addr, input bit we, input logic [3:0] be,
                         input logic [31:0] wd);
        bit ok;
        ls_req_valid = 1'b1;
        ls_req_addr  = addr;
        ls_req_we    = we;
        ls_req_be    = be;
        ls_req_wdata = wd;
        wait_ready(1'b1, ok);
        check("ls_ready", 32'(ok), 32'd1);
        if (ok) begin
            check("ls_mem_addr", mem_addr, addr >> 2);
            check("ls_mem_we", 32'(mem_we), 32'(we && be == 4'hF));
            if (we && be == 4'hF) check("ls_mem_wdata", mem_wdata, wd);
        end
        tick();
        ls_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 30; n++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_resp_valid"}, 32'(if_resp_valid), 32'd0);
        check({tag, "_ls_resp_valid"}, 32'(ls_resp_valid), 32'd0);
        check({tag, "_if_resp_data"}, if_resp_data, 32'h0);
        check({tag, "_ls_resp_data"}, ls_resp_data, 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        rst_n        = 1'b0;
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        ls_req_valid = 1'b0;
        ls_req_addr  = '0;
        ls_req_we    = 1'b0;
        ls_req_be    = 4'h0;
        ls_req_wdata = 32'h0;
        pre_we       = 1'b0;
        pre_idx      = 6'd0;
        pre_data     = 32'h0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;

        preload(16, 32'h1111_0000);
        preload(17, 32'h2222_0000);
        preload(4,  32'hDEAD_BEEF);
        preload(8,  32'h0000_0000);
        preload(2,  32'hAABB_CCDD);
        preload(12, 32'h5566_7788);
        preload(5,  32'hCAFE_F00D);

        $display("[TB] contention");
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h44;
        ls_req_we    = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (grant_log.size() >= 4) break;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        check("contention_grant_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("contention_grant%0d", k),
                  (k < grant_log.size()) ? 32'(grant_log[k]) : 32'd2, 32'(k % 2 == 0));
        end
        drain();

        $display("[TB] fetch");
        do_fetch(32'h10);
        @(negedge clk);
        check("fetch_resp_valid", 32'(if_resp_valid), 32'd1);
        check("fetch_resp_data", if_resp_data, 32'hDEAD_BEEF);
        drain();

        $display("[TB] full store then load");
        do_ls(32'h20, 1'b1, 4'hF, 32'h1234_5678);
        @(negedge clk);
        check("full_store_ack", 32'(ls_resp_valid), 32'd1);
        check("full_store_ack_data", ls_resp_data, 32'h0);
        drain();
        do_ls(32'h20, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("load_after_full_store", ls_resp_data, 32'h1234_5678);
        drain();

        $display("[TB] partial store");
        do_ls(32'h08, 1'b1, 4'b0010, 32'h0000_1100);
        @(negedge clk);
        check("rmw_mem_we", 32'(mem_we), 32'd1);
        check("rmw_mem_wdata", mem_wdata, 32'hAABB_11DD);
        check("rmw_mem_addr", mem_addr, 32'd2);
        check("rmw_no_early_ack", 32'(ls_resp_valid), 32'd0);
        @(negedge clk);
        check("rmw_ack", 32'(ls_resp_valid), 32'd1);
        drain();
        do_ls(32'h08, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("load_after_rmw", ls_resp_data, 32'hAABB_11DD);
        drain();

        $display("[TB] zero byte-enable store");
        w0 = writes_seen;
        do_ls(32'h30, 1'b1, 4'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("zero_be_ack", 32'(ls_resp_valid), 32'd1);
        drain();
        check("zero_be_no_write", 32'(writes_seen), 32'(w0));
        check("zero_be_mem", mem[12], 32'h5566_7788);

        $display("[TB] reset during RMW");
        w0 = writes_seen;
        do_ls(32'h14, 1'b1, 4'b0001, 32'h0000_00AA);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        tick();
        check("mid_reset_no_write", 32'(writes_seen), 32'(w0));
        check("mid_reset_mem", mem[5], 32'hCAFE_F00D);
        rst_n = 1'b1;
        tick();
        do_ls(32'h14, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("load_after_reset", ls_resp_data, 32'hCAFE_F00D);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
